instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Front end of the Yu Core control path. Holds the PC and fetches one 32-bit instruction per
//   retire over a req/ack instruction-memory port, then presents it to the decode/control stage
//   with a valid/ready handshake (opcode, f3, f7 pre-split). Consumes PCSrc/PCTarget from the
//   control unit to select the next PC. Traps on a misaligned fetch target.
// PARAMETERS
//   XLEN      32            address/PC width
//   RESET_PC  32'h0000_0000 PC loaded on reset (must be 4-byte aligned)
// PORTS
//   clk          in   1     core clock, rising edge
//   rst          in   1     asynchronous reset, active-high
//   imemReq      out  1     fetch request; high only in FETCH
//   imemAddr     out  XLEN  fetch address (= PC), stable while imemReq high
//   imemAck      in   1     memory returns imemRdata this cycle
//   imemRdata    in   32    instruction word
//   instrValid   out  1     instr/opcode/f3/f7/PC/PCPlus4 are valid; high only in HOLD
//   instrReady   in   1     decode stage consumes instruction (retire) this cycle
//   instr        out  32    latched instruction
//   opcode       out  7     instr[6:0]
//   f3           out  3     instr[14:12]
//   f7           out  1     instr[30] (funct7 bit 5)
//   PC           out  XLEN  address of instr
//   PCPlus4      out  XLEN  PC + 4, modulo 2^XLEN
//   PCSrc        in   1     take PCTarget; sampled only on retire
//   PCTarget     in   XLEN  branch/jump target
//   misalignErr  out  1     sticky trap flag
//   instret      out  32    retired-instruction counter
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, PC=RESET_PC, instr=32'h0000_0013 (NOP), instret=0,
//     misalignErr=0; hence imemReq=0, instrValid=0. Outstanding request abandoned.
//   - States: IDLE, FETCH, HOLD, TRAP (encoding 2'b00..2'b11).
//   - IDLE: first rising edge after rst low -> FETCH. imemAck ignored.
//   - FETCH: imemReq=1, imemAddr=PC. On imemAck: instr<=imemRdata, -> HOLD. Ack in same cycle
//     as req allowed (zero-wait); min latency req->instrValid = 1 cycle. No ack: stay, hold addr.
//   - HOLD: instrValid=1, outputs frozen. Retire = instrValid & instrReady:
//       next = PCSrc ? PCTarget : PCPlus4; instret<=instret+1 (wraps 2^32-1 -> 0).
//       If next[1:0]!=0: misalignErr<=1, PC unchanged, -> TRAP. Else PC<=next, -> FETCH.
//     No instrReady: stay indefinitely; PCSrc/PCTarget ignored.
//   - TRAP: imemReq=0, instrValid=0, all regs frozen until rst. imemAck ignored.
//   - imemAck outside FETCH is ignored (no latch, no state change).
//   - PCPlus4 and PCTarget wrap modulo 2^XLEN (0xFFFF_FFFC + 4 -> 0).
//   - opcode/f3/f7 are combinational slices of registered instr; imemReq/instrValid decoded from
//     registered state (no combinational path from imemAck or instrReady to any output).
//   - Throughput: zero-wait memory + instrReady tied high -> one retire every 2 cycles.
// STRUCTURE
//   - Parameters.vh: state encodings (IFU_IDLE/FETCH/HOLD/TRAP), NOP constant 32'h0000_0013,
//     instruction field bit ranges shared with MainDecoder/ControlUnit.
//   - Single module; no sub-module. Next-PC mux and adder inline.
// TESTING
//   1 Reset: rst=1 mid-FETCH -> imemReq=0 same cycle, PC=0, instret=0, misalignErr=0,
//     instrValid=0; release -> IDLE one cycle, then imemReq=1, imemAddr=0.
//   2 Zero-wait fetch, instrReady=1, PCSrc=0, memory returns 0x00500093 -> instrValid next cycle,
//     opcode=0x13, f3=0, f7=0; next imemAddr=4; addresses 0,4,8,12 every 2 cycles; instret=4.
//   3 Wait states: imemAck after 3 cycles -> imemAddr stable all 3 cycles; instrValid hold
//     with instrReady=0 for 5 cycles -> instr/PC unchanged, no new imemReq, instret unchanged.
//   4 Branch: PC=0x10, retire with PCSrc=1, PCTarget=0x40 -> next imemAddr=0x40; PCSrc=1 while
//     instrReady=0 -> ignored, PC stays 0x10.
//   5 Misaligned: retire with PCSrc=1, PCTarget=0x42 -> misalignErr=1, state TRAP, imemReq=0,
//     PC unchanged; spurious imemAck ignored; only rst clears.
//   6 Wrap: RESET_PC=0xFFFF_FFFC, retire PCSrc=0 -> imemAddr=0; instret preset 0xFFFF_FFFF
//     via force -> 0 after retire.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e     : fetch FSM states (IDLE/FETCH/HOLD/TRAP, 2'b00..2'b11)
//   instr_fields_t  : pre-split decode fields presented alongside the instruction
//   NOP_INSTR       : reset value of the instruction register (addi x0,x0,0)
//   field ranges    : bit positions shared with the main decoder / control unit
package instruction_fetch_unit_pkg;

  localparam int unsigned ILEN      = 32;
  localparam int unsigned INSTRET_W = 32;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned F3_LSB     = 12;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned F7B5_BIT   = 30;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'b00,
    IFU_FETCH = 2'b01,
    IFU_HOLD  = 2'b10,
    IFU_TRAP  = 2'b11
  } ifu_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [F3_W-1:0]     f3;
    logic                f7;
  } instr_fields_t;

  // Slice the decode fields out of a raw instruction word.
  function automatic instr_fields_t split_instr(input logic [ILEN-1:0] i);
    instr_fields_t f;
    f.opcode = i[OPCODE_LSB +: OPCODE_W];
    f.f3     = i[F3_LSB +: F3_W];
    f.f7     = i[F7B5_BIT];
    return f;
  endfunction

  // Fetch targets must be 4-byte aligned.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory and decode-side bundle of the fetch unit.
//   imem side   : imemReq/imemAddr out, imemAck/imemRdata in
//   decode side : instrValid/instr/opcode/f3/f7/PC/PCPlus4 out, instrReady in
//   control     : PCSrc/PCTarget in
//   status      : misalignErr (sticky trap), instret (retire count)
// master = fetch unit, slave = memory + decode/control environment.
interface instruction_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  import instruction_fetch_unit_pkg::*;

  logic                  imemReq;
  logic [XLEN-1:0]       imemAddr;
  logic                  imemAck;
  logic [ILEN-1:0]       imemRdata;

  logic                  instrValid;
  logic                  instrReady;
  logic [ILEN-1:0]       instr;
  logic [OPCODE_W-1:0]   opcode;
  logic [F3_W-1:0]       f3;
  logic                  f7;
  logic [XLEN-1:0]       PC;
  logic [XLEN-1:0]       PCPlus4;

  logic                  PCSrc;
  logic [XLEN-1:0]       PCTarget;

  logic                  misalignErr;
  logic [INSTRET_W-1:0]  instret;

  modport master (
    output imemReq, imemAddr, instrValid, instr, opcode, f3, f7, PC, PCPlus4,
           misalignErr, instret,
    input  imemAck, imemRdata, instrReady, PCSrc, PCTarget
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, opcode, f3, f7, PC, PCPlus4,
           misalignErr, instret,
    output imemAck, imemRdata, instrReady, PCSrc, PCTarget
  );

endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one instruction per retire over
// a req/ack memory port and presents it to decode with a valid/ready handshake.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : instruction_fetch_unit_if.master (imem port, decode handshake,
//          next-PC control, misalignErr trap flag, instret counter)
// Parameters: XLEN (PC width), RESET_PC (4-byte aligned PC loaded on reset).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  bus
);

  ifu_state_e           state_q,    state_d;
  logic [XLEN-1:0]      pc_q,       pc_d;
  logic [ILEN-1:0]      instr_q,    instr_d;
  logic [INSTRET_W-1:0] instret_q,  instret_d;
  logic                 misalign_q, misalign_d;

  logic [XLEN-1:0]      pc_plus4;
  logic [XLEN-1:0]      next_pc;
  logic                 retire;
  instr_fields_t        fields;

  // Next-PC mux; adder wraps naturally modulo 2^XLEN.
  assign pc_plus4 = pc_q + XLEN'(4);
  assign next_pc  = bus.PCSrc ? bus.PCTarget : pc_plus4;
  assign retire   = (state_q == IFU_HOLD) && bus.instrReady;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFU_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instret_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instret_q  <= instret_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic; everything holds unless a transition updates it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instret_d  = instret_q;
    misalign_d = misalign_q;

    case (state_q)
      IFU_IDLE: begin
        state_d = IFU_FETCH;
      end
      IFU_FETCH: begin
        if (bus.imemAck) begin
          instr_d = bus.imemRdata;
          state_d = IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        if (retire) begin
          instret_d = instret_q + INSTRET_W'(1);
          // A misaligned target retires the current instruction but traps
          // instead of fetching; PC keeps pointing at the faulting retire.
          if (!is_word_aligned(next_pc[1:0])) begin
            misalign_d = 1'b1;
            state_d    = IFU_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = IFU_FETCH;
          end
        end
      end
      IFU_TRAP: begin
        state_d = IFU_TRAP;
      end
      default: begin
        state_d = IFU_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, never imemAck/instrReady.
  assign fields = split_instr(instr_q);

  assign bus.imemReq     = (state_q == IFU_FETCH);
  assign bus.imemAddr    = pc_q;
  assign bus.instrValid  = (state_q == IFU_HOLD);
  assign bus.instr       = instr_q;
  assign bus.opcode      = fields.opcode;
  assign bus.f3          = fields.f3;
  assign bus.f7          = fields.f7;
  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.misalignErr = misalign_q;
  assign bus.instret     = instret_q;

endmodule
